mips_multicycle_ctrl: RTL and testbench

- Multicycle MIPS main control FSM. It is the driving end of the ALU interface: it issues the 4-bit ALU function code and operand selects, and it consumes the ALU zero flag for branches.
- It also sequences the PC, IR, memory and register-file enables for the shared-ALU datapath.
- It sits between the instruction register (opcode/funct inputs) and the datapath muxes and write enables.

---
 rtl/mips_multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Main control FSM for a multicycle MIPS datapath with a shared ALU. It
// sequences PC/IR/memory/register-file enables and drives the ALU function
// code and operand selects, consuming the ALU zero flag for branches.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode, funct       IR[31:26] / IR[5:0], held stable by the IR after DECODE
//   zero                ALU zero flag
//   alu_control         ALU function code
//   alu_src_a/b         ALU operand selects
//   pc_source, pc_en    PC next-value select and write enable
//   iord                memory address select (0=PC, 1=ALUOut)
//   mem_read/mem_write  memory strobes
//   ir_write            IR load enable
//   reg_dst, mem_to_reg register-file write address/data selects
//   reg_write           register-file write enable
//   instr_done          pulse in the final state of each instruction
//   illegal             high while in the ILLEGAL state
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter bit ILLEGAL_TRAP = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [3:0] alu_control,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic       pc_en,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       instr_done,
   output logic       illegal
);

   localparam int unsigned OPW = 6;
   localparam int unsigned ALUW = 4;

   localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPW-1:0] OP_LW    = 6'b100011;
   localparam logic [OPW-1:0] OP_SW    = 6'b101011;
   localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
   localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPW-1:0] OP_J     = 6'b000010;

   localparam logic [OPW-1:0] FN_ADD   = 6'b100000;
   localparam logic [OPW-1:0] FN_SUB   = 6'b100010;
   localparam logic [OPW-1:0] FN_AND   = 6'b100100;
   localparam logic [OPW-1:0] FN_OR    = 6'b100101;
   localparam logic [OPW-1:0] FN_XNOR  = 6'b100111;
   localparam logic [OPW-1:0] FN_MINU  = 6'b101000;
   localparam logic [OPW-1:0] FN_JR    = 6'b001000;

   localparam logic [ALUW-1:0] ALU_AND  = 4'b0000;
   localparam logic [ALUW-1:0] ALU_OR   = 4'b0001;
   localparam logic [ALUW-1:0] ALU_ADD  = 4'b0010;
   localparam logic [ALUW-1:0] ALU_PASS = 4'b0011;
   localparam logic [ALUW-1:0] ALU_SUB  = 4'b0110;
   localparam logic [ALUW-1:0] ALU_MINU = 4'b0111;
   localparam logic [ALUW-1:0] ALU_XNOR = 4'b1100;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTEX    = 4'd6,
      S_RTWB    = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11,
      S_JR      = 4'd12,
      S_ILLEGAL = 4'd13
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             rt_legal_c;
   logic [ALUW-1:0]  rt_alu_c;

   // R-type funct decode: legality and ALU function code
   always_comb begin
      rt_legal_c = 1'b1;
      rt_alu_c   = ALU_ADD;
      case (funct)
         FN_ADD:  rt_alu_c = ALU_ADD;
         FN_SUB:  rt_alu_c = ALU_SUB;
         FN_AND:  rt_alu_c = ALU_AND;
         FN_OR:   rt_alu_c = ALU_OR;
         FN_XNOR: rt_alu_c = ALU_XNOR;
         FN_MINU: rt_alu_c = ALU_MINU;
         default: rt_legal_c = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; unused encodings fall back to FETCH
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW:   state_d = S_MEMADR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_ADDI:        state_d = S_ADDIEX;
               OP_J:           state_d = S_JUMP;
               OP_RTYPE: begin
                  if (funct == FN_JR) begin
                     state_d = S_JR;
                  end else if (rt_legal_c) begin
                     state_d = S_RTEX;
                  end else begin
                     state_d = S_ILLEGAL;
                  end
               end
               default:        state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = S_MEMWB;
         S_RTEX:    state_d = S_RTWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ILLEGAL: state_d = ILLEGAL_TRAP ? S_ILLEGAL : S_FETCH;
         default:   state_d = S_FETCH;
      endcase
   end

   // Output decode; reset masks everything to the default set so that no
   // write enable can fire in the cycle reset is asserted
   always_comb begin
      alu_control = ALU_ADD;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      pc_source   = 2'b00;
      pc_en       = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      instr_done  = 1'b0;
      illegal     = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               ir_write  = 1'b1;
               alu_src_b = 2'b01;
               pc_en     = 1'b1;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               instr_done = 1'b1;
            end
            S_MEMWR: begin
               mem_write  = 1'b1;
               iord       = 1'b1;
               instr_done = 1'b1;
            end
            S_RTEX: begin
               alu_src_a   = 1'b1;
               alu_control = rt_alu_c;
            end
            S_RTWB: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               instr_done = 1'b1;
            end
            S_BRANCH: begin
               // bne inverts the sense of the zero flag
               alu_src_a   = 1'b1;
               alu_control = ALU_SUB;
               pc_source   = 2'b01;
               pc_en       = zero ^ (opcode == OP_BNE);
               instr_done  = 1'b1;
            end
            S_ADDIWB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            S_JUMP: begin
               pc_source  = 2'b10;
               pc_en      = 1'b1;
               instr_done = 1'b1;
            end
            S_JR: begin
               alu_src_a   = 1'b1;
               alu_control = ALU_PASS;
               pc_en       = 1'b1;
               instr_done  = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Drives instruction sequences into two controller instances (normal and
// trapping illegal handling) and compares every cycle's outputs against an
// instruction-level reference: each instruction class is a list of per-cycle
// output sets counted from its FETCH cycle.
// ----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

   typedef struct packed {
      logic [3:0] alu;
      logic       src_a;
      logic [1:0] src_b;
      logic [1:0] pc_src;
      logic       pc_en;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       instr_done;
      logic       illegal;
   } outv_t;

   typedef enum int {C_LW, C_SW, C_RT, C_BR, C_ADDI, C_J, C_JR, C_ILL} cls_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rst_trap = 1'b1;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       chk_trap = 1'b0;

   logic [3:0] alu_control, alu_control_t;
   logic       alu_src_a, alu_src_a_t;
   logic [1:0] alu_src_b, alu_src_b_t;
   logic [1:0] pc_source, pc_source_t;
   logic       pc_en, pc_en_t, iord, iord_t, mem_read, mem_read_t;
   logic       mem_write, mem_write_t, ir_write, ir_write_t, reg_dst, reg_dst_t;
   logic       mem_to_reg, mem_to_reg_t, reg_write, reg_write_t;
   logic       instr_done, instr_done_t, illegal, illegal_t;

   outv_t obs, obs_trap;

   int checks = 0;
   int errors = 0;

   logic [5:0] rt_fn [6] = '{6'b100000, 6'b100010, 6'b100100,
                             6'b100101, 6'b100111, 6'b101000};

   always #5 clk = ~clk;

   mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_source(pc_source), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .instr_done(instr_done),
      .illegal(illegal)
   );

   mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut_trap (
      .clk(clk), .rst(rst_trap), .opcode(opcode), .funct(funct), .zero(zero),
      .alu_control(alu_control_t), .alu_src_a(alu_src_a_t), .alu_src_b(alu_src_b_t),
      .pc_source(pc_source_t), .pc_en(pc_en_t), .iord(iord_t), .mem_read(mem_read_t),
      .mem_write(mem_write_t), .ir_write(ir_write_t), .reg_dst(reg_dst_t),
      .mem_to_reg(mem_to_reg_t), .reg_write(reg_write_t), .instr_done(instr_done_t),
      .illegal(illegal_t)
   );

   assign obs = {alu_control, alu_src_a, alu_src_b, pc_source, pc_en, iord,
                 mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                 instr_done, illegal};
   assign obs_trap = {alu_control_t, alu_src_a_t, alu_src_b_t, pc_source_t, pc_en_t,
                      iord_t, mem_read_t, mem_write_t, ir_write_t, reg_dst_t,
                      mem_to_reg_t, reg_write_t, instr_done_t, illegal_t};

   function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b100011: return C_LW;
         6'b101011: return C_SW;
         6'b000100, 6'b000101: return C_BR;
         6'b001000: return C_ADDI;
         6'b000010: return C_J;
         6'b000000: begin
            if (fn == 6'b001000) return C_JR;
            for (int i = 0; i < 6; i++) if (fn == rt_fn[i]) return C_RT;
            return C_ILL;
         end
         default: return C_ILL;
      endcase
   endfunction

   // cycles from FETCH up to the final state (ILLEGAL counted as its one cycle)
   function automatic int n_cycles(input cls_t c);
      case (c)
         C_LW: return 5;
         C_SW, C_RT, C_ADDI: return 4;
         default: return 3;
      endcase
   endfunction

   function automatic logic [3:0] rt_alu(input logic [5:0] fn);
      case (fn)
         6'b100000: return 4'b0010;
         6'b100010: return 4'b0110;
         6'b100100: return 4'b0000;
         6'b100101: return 4'b0001;
         6'b100111: return 4'b1100;
         default:   return 4'b0111;
      endcase
   endfunction

   function automatic outv_t def_out();
      outv_t v = '0;
      v.alu = 4'b0010;
      return v;
   endfunction

   // expected outputs for cycle 'step' of an instruction (step 0 = FETCH)
   function automatic outv_t exp_out(input cls_t c, input int step,
                                     input logic [5:0] op, input logic [5:0] fn,
                                     input logic z);
      outv_t v = def_out();
      if (step == 0) begin
         v.mem_read = 1'b1; v.ir_write = 1'b1; v.src_b = 2'b01; v.pc_en = 1'b1;
      end else if (step == 1) begin
         v.src_b = 2'b11;
      end else begin
         case (c)
            C_LW, C_SW: begin
               if (step == 2) begin
                  v.src_a = 1'b1; v.src_b = 2'b10;
               end else if (c == C_SW) begin
                  v.mem_write = 1'b1; v.iord = 1'b1; v.instr_done = 1'b1;
               end else if (step == 3) begin
                  v.mem_read = 1'b1; v.iord = 1'b1;
               end else begin
                  v.reg_write = 1'b1; v.mem_to_reg = 1'b1; v.instr_done = 1'b1;
               end
            end
            C_RT: begin
               if (step == 2) begin
                  v.src_a = 1'b1; v.alu = rt_alu(fn);
               end else begin
                  v.reg_write = 1'b1; v.reg_dst = 1'b1; v.instr_done = 1'b1;
               end
            end
            C_ADDI: begin
               if (step == 2) begin
                  v.src_a = 1'b1; v.src_b = 2'b10;
               end else begin
                  v.reg_write = 1'b1; v.instr_done = 1'b1;
               end
            end
            C_BR: begin
               v.src_a = 1'b1; v.alu = 4'b0110; v.pc_src = 2'b01; v.instr_done = 1'b1;
               v.pc_en = (op == 6'b000100) ? z : !z;
            end
            C_J: begin
               v.pc_src = 2'b10; v.pc_en = 1'b1; v.instr_done = 1'b1;
            end
            C_JR: begin
               v.src_a = 1'b1; v.alu = 4'b0011; v.pc_en = 1'b1; v.instr_done = 1'b1;
            end
            default: v.illegal = 1'b1;
         endcase
      end
      return v;
   endfunction

   task automatic check(input string tag, input outv_t o, input outv_t e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   // Run one instruction from its FETCH cycle; limit>0 stops early
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input string name, input int limit);
      cls_t c = classify(op, fn);
      int   n = n_cycles(c);
      outv_t e;
      if (limit > 0 && limit < n) n = limit;
      for (int s = 0; s < n; s++) begin
         @(posedge clk); #1;
         rst = 1'b0;
         if (chk_trap) rst_trap = 1'b0;
         if (s == 0) begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
         end else begin
            opcode = op;
            funct  = fn;
         end
         zero = z;
         @(negedge clk);
         e = exp_out(c, s, op, fn, z);
         check($sformatf("%s step%0d", name, s), obs, e);
         if (chk_trap) check($sformatf("trap %s step%0d", name, s), obs_trap, e);
      end
   endtask

   initial begin
      logic [5:0] op, fn;
      logic       z;
      int         k;

      // reset held for two cycles: default outputs on both instances
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("reset", obs, def_out());
         check("reset trap", obs_trap, def_out());
      end

      // directed instructions
      run_instr(6'b100011, 6'b000000, 1'b0, "lw", 0);
      for (int i = 0; i < 6; i++) run_instr(6'b000000, rt_fn[i], 1'b0, "rtype", 0);
      run_instr(6'b000100, 6'b010101, 1'b1, "beq_taken", 0);
      run_instr(6'b000100, 6'b010101, 1'b0, "beq_not", 0);
      run_instr(6'b000101, 6'b000000, 1'b0, "bne_taken", 0);
      run_instr(6'b000101, 6'b000000, 1'b1, "bne_not", 0);
      run_instr(6'b000000, 6'b001000, 1'b0, "jr", 0);
      run_instr(6'b000010, 6'b111111, 1'b0, "j", 0);
      run_instr(6'b001000, 6'b000000, 1'b0, "addi", 0);
      run_instr(6'b101011, 6'b000000, 1'b0, "sw", 0);
      run_instr(6'b111111, 6'b000000, 1'b0, "ill_op", 0);
      run_instr(6'b000000, 6'b000001, 1'b0, "ill_fn", 0);
      run_instr(6'b100011, 6'b000000, 1'b0, "lw_after_ill", 0);

      // reset during MEMWR of sw: write strobe suppressed, then clean FETCH
      run_instr(6'b101011, 6'b000000, 1'b0, "sw_abort", 3);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("abort reset cycle", obs, def_out());
      run_instr(6'b100011, 6'b000000, 1'b0, "lw_after_abort", 0);

      // trapping instance: stays illegal until reset
      chk_trap = 1'b1;
      run_instr(6'b111111, 6'b000000, 1'b0, "ill_trap", 0);
      chk_trap = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         opcode = 6'($urandom);
         funct  = 6'($urandom);
         @(negedge clk);
         check($sformatf("trap hold %0d", i), obs_trap,
               exp_out(C_ILL, 2, 6'b111111, 6'b000000, 1'b0));
      end
      @(posedge clk); #1;
      rst = 1'b1;
      rst_trap = 1'b1;
      @(negedge clk);
      check("trap reset", obs_trap, def_out());
      check("main reset", obs, def_out());
      chk_trap = 1'b1;
      run_instr(6'b000000, 6'b001000, 1'b0, "jr_after_trap", 0);
      chk_trap = 1'b0;

      // randomized instruction stream
      for (int i = 0; i < 300; i++) begin
         k  = int'($urandom_range(0, 8));
         z  = 1'($urandom);
         fn = 6'($urandom);
         case (k)
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: begin op = 6'b000000; fn = rt_fn[$urandom_range(0, 5)]; end
            3: op = 6'b000100;
            4: op = 6'b000101;
            5: op = 6'b001000;
            6: op = 6'b000010;
            7: begin op = 6'b000000; fn = 6'b001000; end
            default: begin
               if (1'($urandom)) begin
                  op = 6'($urandom);
                  while (classify(op, fn) != C_ILL) op = 6'($urandom);
               end else begin
                  op = 6'b000000;
                  while (classify(op, fn) != C_ILL) fn = 6'($urandom);
               end
            end
         endcase
         run_instr(op, fn, z, $sformatf("rand%0d", i), 0);
      end
      run_instr(6'b000010, 6'b000000, 1'b0, "final_j", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
